// File: rtl/ro_count_capture.sv
// Ring-oscillator edge-count reader: accumulates wrap-corrected per-cycle deltas of a
// free-running counter over a fixed gate window and offers the total via valid/ready.
module ro_count_capture #(
  parameter int unsigned CW          = 8,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned GATE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    count_in,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic [ACC_W-1:0] result,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  // Timer counts GATE_CYCLES-1 down to 0; keep at least one bit for GATE_CYCLES=1.
  localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] TimerLoad = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGate, StHold} state_e;

  state_e           state;
  logic [CW-1:0]    prev;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [TW-1:0]    timer;

  logic [CW-1:0]    delta;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;

  // Modular delta absorbs counter wraps; the carry out of the sum marks saturation.
  always_comb begin
    delta    = count_in - prev;
    sum      = {1'b0, acc} + {{(ACC_W + 1 - CW){1'b0}}, delta};
    acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    ovf_next = ovf | sum[ACC_W];
  end

  // Measurement FSM with registered outputs; abort outranks start and the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      prev         <= '0;
      acc          <= '0;
      ovf          <= 1'b0;
      timer        <= '0;
      busy         <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            prev  <= count_in;
            acc   <= '0;
            ovf   <= 1'b0;
            timer <= TimerLoad;
            busy  <= 1'b1;
            state <= StGate;
          end
        end
        StGate: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= StIdle;
          end else begin
            acc  <= acc_next;
            ovf  <= ovf_next;
            prev <= count_in;
            if (timer == '0) begin
              result       <= acc_next;
              overflow     <= ovf_next;
              result_valid <= 1'b1;
              state        <= StHold;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end
        StHold: begin
          if (abort) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= StIdle;
          end else if (result_ready) begin
            result_valid <= 1'b0;
            if (start) begin
              // Back-to-back measurement: new baseline this edge, no idle cycle.
              prev  <= count_in;
              acc   <= '0;
              ovf   <= 1'b0;
              timer <= TimerLoad;
              state <= StGate;
            end else begin
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end
        default: begin
          busy         <= 1'b0;
          result_valid <= 1'b0;
          state        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_count_capture.sv
// Directed bench for ro_count_capture: default instance plus a narrow saturating
// instance and a single-cycle-gate instance, all fed by one stepping count bus.
module tb_ro_count_capture;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cnt;
  logic [7:0]  stp;
  logic        start, start_s, start_1;
  logic        abort;
  logic        ready;

  logic        busy, ovf, valid;
  logic [15:0] res;
  logic        busy_s, ovf_s, valid_s;
  logic [9:0]  res_s;
  logic        busy_1, ovf_1, valid_1;
  logic [15:0] res_1;

  int n_cmp = 0;
  int n_bad = 0;

  ro_count_capture #(.CW(8), .ACC_W(16), .GATE_CYCLES(1000)) u_dut (
    .clk(clk), .rst_n(rst_n), .count_in(cnt), .start(start), .abort(abort),
    .busy(busy), .result(res), .overflow(ovf), .result_valid(valid), .result_ready(ready)
  );

  ro_count_capture #(.CW(8), .ACC_W(10), .GATE_CYCLES(2000)) u_sat (
    .clk(clk), .rst_n(rst_n), .count_in(cnt), .start(start_s), .abort(abort),
    .busy(busy_s), .result(res_s), .overflow(ovf_s), .result_valid(valid_s),
    .result_ready(ready)
  );

  ro_count_capture #(.CW(8), .ACC_W(16), .GATE_CYCLES(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .count_in(cnt), .start(start_1), .abort(abort),
    .busy(busy_1), .result(res_1), .overflow(ovf_1), .result_valid(valid_1),
    .result_ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; inputs and the count bus move 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cnt = cnt + stp;
  endtask

  task automatic fire_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start edge until valid; optional start re-pulse at cycle mid_at.
  task automatic wait_valid(input int budget, input int mid_at, output int n);
    n = 0;
    while (!valid && n < budget) begin
      if (n == mid_at) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
  endtask

  task automatic release_result();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  initial begin
    int n;
    int saw;
    rst_n = 1'b0; cnt = 8'd0; stp = 8'd1;
    start = 1'b0; start_s = 1'b0; start_1 = 1'b0; abort = 1'b0; ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(res), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1 + T4: +1/cycle, then hold ready low for 5 cycles.
    cnt = 8'd0; stp = 8'd1;
    fire_start();
    check("t1_busy", 32'(busy), 32'd1);
    wait_valid(1100, -1, n);
    check("t1_latency", 32'(n), 32'd1000);
    check("t1_result", 32'(res), 32'd1000);
    check("t1_overflow", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_valid_held", 32'(valid), 32'd1);
      check("t4_result_held", 32'(res), 32'd1000);
    end
    release_result();
    check("t4_valid_drop", 32'(valid), 32'd0);
    check("t4_idle", 32'(busy), 32'd0);

    // T2: +3/cycle from 250, wrapping many times over the gate.
    cnt = 8'd250; stp = 8'd3;
    fire_start();
    wait_valid(1100, -1, n);
    check("t2_latency", 32'(n), 32'd1000);
    check("t2_result", 32'(res), 32'd3000);
    check("t2_overflow", 32'(ovf), 32'd0);
    release_result();

    // T5: mid-gate start ignored; handshake with start restarts without idling.
    stp = 8'd1;
    fire_start();
    wait_valid(1100, 500, n);
    check("t5_latency", 32'(n), 32'd1000);
    check("t5_result", 32'(res), 32'd1000);
    ready = 1'b1; start = 1'b1;
    tick();
    ready = 1'b0; start = 1'b0;
    check("t5_restart_busy", 32'(busy), 32'd1);
    check("t5_restart_valid", 32'(valid), 32'd0);
    wait_valid(1100, -1, n);
    check("t5_b2b_latency", 32'(n), 32'd1000);
    check("t5_b2b_result", 32'(res), 32'd1000);

    // Abort while holding: valid drops, result keeps its value.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("hold_abort_valid", 32'(valid), 32'd0);
    check("hold_abort_busy", 32'(busy), 32'd0);
    check("hold_abort_result", 32'(res), 32'd1000);

    // T6: abort at gate cycle 400; valid must never rise afterwards.
    stp = 8'd2;
    fire_start();
    repeat (399) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_busy", 32'(busy), 32'd0);
    saw = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (valid) saw++;
    end
    check("t6_no_valid", 32'(saw), 32'd0);
    check("t6_result_kept", 32'(res), 32'd1000);

    // T6: reset at gate cycle 500 clears outputs immediately.
    fire_start();
    repeat (499) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_result", 32'(res), 32'd0);
    check("t6_rst_overflow", 32'(ovf), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fire_start();
    wait_valid(1100, -1, n);
    check("t6_fresh_latency", 32'(n), 32'd1000);
    check("t6_fresh_result", 32'(res), 32'd2000);
    release_result();

    // T3: narrow accumulator saturates and flags overflow.
    stp = 8'd1;
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    n = 0;
    while (!valid_s && n < 2100) begin
      tick();
      n++;
    end
    check("t3_latency", 32'(n), 32'd2000);
    check("t3_result", 32'(res_s), 32'd1023);
    check("t3_overflow", 32'(ovf_s), 32'd1);
    release_result();
    check("t3_valid_drop", 32'(valid_s), 32'd0);

    // Single-cycle gate: one delta, valid on the cycle after start.
    stp = 8'd5;
    start_1 = 1'b1;
    tick();
    start_1 = 1'b0;
    check("g1_busy", 32'(busy_1), 32'd1);
    check("g1_valid_early", 32'(valid_1), 32'd0);
    tick();
    check("g1_valid", 32'(valid_1), 32'd1);
    check("g1_result", 32'(res_1), 32'd5);
    check("g1_overflow", 32'(ovf_1), 32'd0);
    release_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
